lsu_mem_ctrl: RTL and testbench

Load/store controller between the RISC-V core's memory stage and the single-port data SRAM. Accepts byte-addressed RV32I load/store requests over a valid/ready handshake and drives the SRAM's active-low chip-select, active-low write-enable, byte-enable and word-address pins. Formats load data with RV32I sign or zero extension. Optionally splits word-misaligned accesses into two SRAM word accesses.

---
 rtl/lsu_mem_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store controller driving a single-port, active-low-strobe data SRAM.
// Define MISALIGN_SPLIT_EN to split word-spanning accesses into two SRAM accesses; otherwise they fault.
module lsu_mem_ctrl #(
    parameter int unsigned AWIDTH = 12
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WE,
    input  logic [2:0]        REQ_FUNCT3,
    input  logic [31:0]       REQ_ADDR,
    input  logic [31:0]       REQ_WDATA,
    output logic              RSP_VALID,
    output logic [31:0]       RSP_RDATA,
    output logic              RSP_ERR,
    output logic              MEM_CSN,
    output logic              MEM_WEN,
    output logic [AWIDTH-1:0] MEM_ADDR,
    output logic [3:0]        MEM_BE,
    output logic [31:0]       MEM_DI,
    input  logic [31:0]       MEM_DOUT
);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, WAIT} state_t;

    state_t state, state_d;

    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
`ifdef MISALIGN_SPLIT_EN
    logic [AWIDTH-1:0] word_q, word_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              span_q, span_d;
    logic [31:0]       first_q, first_d;
    logic [7:0]        be8_q;
`endif

    logic              rsp_valid_d, rsp_err_d;
    logic [31:0]       rsp_rdata_d;
    logic              csn_d, wen_d;
    logic [3:0]        be_d;
    logic [AWIDTH-1:0] addr_d;
    logic [31:0]       di_d;

    logic [1:0]  req_off;
    logic [2:0]  req_size;
    logic        req_span, req_illegal, req_range, req_err;
    logic [7:0]  req_be8;
    logic [63:0] load_cat, load_shift;
    logic [31:0] load_word, load_fmt;

    function automatic logic [3:0] size_mask(input logic [1:0] f3lo);
        case (f3lo)
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    assign REQ_READY = (state == IDLE);

    always_comb begin
        req_off = REQ_ADDR[1:0];
        case (REQ_FUNCT3[1:0])
            2'b00:   req_size = 3'd1;
            2'b01:   req_size = 3'd2;
            default: req_size = 3'd4;
        endcase
        req_span    = (3'(req_off) + req_size) > 3'd4;
        req_illegal = REQ_WE ? (REQ_FUNCT3 > 3'b010)
                             : ((REQ_FUNCT3 == 3'b011) || (REQ_FUNCT3[2:1] == 2'b11));
        req_range   = |REQ_ADDR[31:AWIDTH+2];
`ifdef MISALIGN_SPLIT_EN
        req_err     = req_range | req_illegal;
`else
        req_err     = req_range | req_illegal | req_span;
`endif
        req_be8     = {4'b0000, size_mask(REQ_FUNCT3[1:0])} << req_off;
    end

`ifdef MISALIGN_SPLIT_EN
    assign be8_q    = {4'b0000, size_mask(f3_q[1:0])} << off_q;
    assign load_cat = span_q ? {MEM_DOUT, first_q} : {32'h0, MEM_DOUT};
`else
    assign load_cat = {32'h0, MEM_DOUT};
`endif

    always_comb begin
        load_shift = load_cat >> {off_q, 3'b000};
        load_word  = load_shift[31:0];
        case (f3_q)
            3'b000:  load_fmt = {{24{load_word[7]}}, load_word[7:0]};
            3'b001:  load_fmt = {{16{load_word[15]}}, load_word[15:0]};
            3'b100:  load_fmt = {24'h0, load_word[7:0]};
            3'b101:  load_fmt = {16'h0, load_word[15:0]};
            default: load_fmt = load_word;
        endcase
    end

    always_comb begin
        state_d     = state;
        off_d       = off_q;
        f3_d        = f3_q;
        we_d        = we_q;
        err_d       = err_q;
`ifdef MISALIGN_SPLIT_EN
        word_d      = word_q;
        wdata_d     = wdata_q;
        span_d      = span_q;
        first_d     = first_q;
`endif
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        csn_d       = 1'b1;
        wen_d       = 1'b1;
        be_d        = '0;
        addr_d      = MEM_ADDR;
        di_d        = MEM_DI;

        case (state)
            IDLE: begin
                if (REQ_VALID) begin
                    state_d = ACC1;
                    off_d   = req_off;
                    f3_d    = REQ_FUNCT3;
                    we_d    = REQ_WE;
                    err_d   = req_err;
`ifdef MISALIGN_SPLIT_EN
                    word_d  = REQ_ADDR[AWIDTH+1:2];
                    wdata_d = REQ_WDATA;
                    span_d  = req_span;
`endif
                    // Faulting requests still pass through ACC1 with the SRAM deselected.
                    if (!req_err) begin
                        csn_d  = 1'b0;
                        wen_d  = ~REQ_WE;
                        be_d   = req_be8[3:0];
                        addr_d = REQ_ADDR[AWIDTH+1:2];
                        di_d   = REQ_WDATA << {req_off, 3'b000};
                    end
                end
            end
            ACC1: begin
                if (err_q) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
`ifdef MISALIGN_SPLIT_EN
                end else if (span_q) begin
                    state_d = ACC2;
                    csn_d   = 1'b0;
                    wen_d   = ~we_q;
                    be_d    = be8_q[7:4];
                    addr_d  = AWIDTH'(word_q + 1'b1);
                    di_d    = wdata_q >> (6'd32 - 6'({off_q, 3'b000}));
`endif
                end else if (we_q) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
`ifdef MISALIGN_SPLIT_EN
            ACC2: begin
                if (we_q) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                end else begin
                    first_d = MEM_DOUT;
                    state_d = WAIT;
                end
            end
`endif
            WAIT: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = load_fmt;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state     <= IDLE;
            off_q     <= '0;
            f3_q      <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
            word_q    <= '0;
            wdata_q   <= '0;
            span_q    <= 1'b0;
            first_q   <= '0;
`endif
            RSP_VALID <= 1'b0;
            RSP_ERR   <= 1'b0;
            RSP_RDATA <= '0;
            MEM_CSN   <= 1'b1;
            MEM_WEN   <= 1'b1;
            MEM_BE    <= '0;
            MEM_ADDR  <= '0;
            MEM_DI    <= '0;
        end else begin
            state     <= state_d;
            off_q     <= off_d;
            f3_q      <= f3_d;
            we_q      <= we_d;
            err_q     <= err_d;
`ifdef MISALIGN_SPLIT_EN
            word_q    <= word_d;
            wdata_q   <= wdata_d;
            span_q    <= span_d;
            first_q   <= first_d;
`endif
            RSP_VALID <= rsp_valid_d;
            RSP_ERR   <= rsp_err_d;
            RSP_RDATA <= rsp_rdata_d;
            MEM_CSN   <= csn_d;
            MEM_WEN   <= wen_d;
            MEM_BE    <= be_d;
            MEM_ADDR  <= addr_d;
            MEM_DI    <= di_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: SRAM model, response scoreboard and SRAM access log.
// Split-path scenarios are selected by MISALIGN_SPLIT_EN, matching the RTL build.
module tb_lsu_mem_ctrl;

    localparam int unsigned AW = 12;

    logic          CLK, RSTn;
    logic          REQ_VALID, REQ_READY, REQ_WE;
    logic [2:0]    REQ_FUNCT3;
    logic [31:0]   REQ_ADDR, REQ_WDATA;
    logic          RSP_VALID, RSP_ERR;
    logic [31:0]   RSP_RDATA;
    logic          MEM_CSN, MEM_WEN;
    logic [AW-1:0] MEM_ADDR;
    logic [3:0]    MEM_BE;
    logic [31:0]   MEM_DI, MEM_DOUT;

    lsu_mem_ctrl #(.AWIDTH(AW)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_FUNCT3(REQ_FUNCT3), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .MEM_CSN(MEM_CSN), .MEM_WEN(MEM_WEN), .MEM_ADDR(MEM_ADDR),
        .MEM_BE(MEM_BE), .MEM_DI(MEM_DI), .MEM_DOUT(MEM_DOUT)
    );

    typedef struct {
        logic          wen;
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [31:0]   di;
    } access_t;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic [31:0] mem [0:(1<<AW)-1];
    access_t     log_q[$];
    exp_t        sb[$];
    int          cyc = 0;
    int          passed = 0;
    int          total = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Synchronous SRAM: read data appears in the cycle after the read edge.
    always @(posedge CLK) begin
        if (!MEM_CSN) begin
            log_q.push_back('{MEM_WEN, MEM_ADDR, MEM_BE, MEM_DI});
            if (!MEM_WEN) begin
                for (int b = 0; b < 4; b++)
                    if (MEM_BE[b]) mem[MEM_ADDR][8*b +: 8] <= MEM_DI[8*b +: 8];
            end else begin
                MEM_DOUT <= mem[MEM_ADDR];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic access_t mk(input logic wen, input logic [AW-1:0] addr,
                                   input logic [3:0] be, input logic [31:0] di);
        mk = '{wen, addr, be, di};
    endfunction

    always @(negedge CLK) begin
        if (RSTn && RSP_VALID) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'(RSP_VALID), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.tag, "_rdata"}, RSP_RDATA, e.rdata);
                check({e.tag, "_err"}, 32'(RSP_ERR), 32'(e.err));
                check({e.tag, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    // Called at a negedge with the controller idle; returns at the negedge showing RSP_VALID.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                          input int nacc, input access_t a0, input access_t a1);
        logic    seen;
        access_t ea[2];
        ea[0] = a0;
        ea[1] = a1;
        check({tag, "_ready"}, 32'(REQ_READY), 32'd1);
        log_q.delete();
        sb.push_back('{tag, exp_rdata, exp_err, exp_lat, cyc + 1});
        REQ_VALID  = 1'b1;
        REQ_WE     = we;
        REQ_FUNCT3 = f3;
        REQ_ADDR   = addr;
        REQ_WDATA  = wdata;
        @(posedge CLK);
        #1 REQ_VALID = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge CLK);
            seen = RSP_VALID;
        end
        if (!seen) check({tag, "_timeout"}, 32'(RSP_VALID), 32'd1);
        check({tag, "_naccess"}, 32'(log_q.size()), 32'(nacc));
        for (int i = 0; i < nacc && i < log_q.size(); i++) begin
            check($sformatf("%s_acc%0d_wen", tag, i), 32'(log_q[i].wen), 32'(ea[i].wen));
            check($sformatf("%s_acc%0d_addr", tag, i), 32'(log_q[i].addr), 32'(ea[i].addr));
            check($sformatf("%s_acc%0d_be", tag, i), 32'(log_q[i].be), 32'(ea[i].be));
            if (we) check($sformatf("%s_acc%0d_di", tag, i), log_q[i].di, ea[i].di);
        end
    endtask

    initial begin
        access_t na;
        logic [31:0] last_w1;
        na = mk(1'b1, '0, '0, '0);
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[0]    = 32'h12345678;
        mem[1]    = 32'h44332211;
        mem[2]    = 32'h88776655;
        mem[4095] = 32'hCAFEBABE;
        MEM_DOUT   = '0;
        RSTn       = 1'b0;
        REQ_VALID  = 1'b0;
        REQ_WE     = 1'b0;
        REQ_FUNCT3 = '0;
        REQ_ADDR   = '0;
        REQ_WDATA  = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_ready", 32'(REQ_READY), 32'd1);
        check("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        check("rst_rsp_rdata", RSP_RDATA, 32'd0);
        check("rst_rsp_err", 32'(RSP_ERR), 32'd0);
        check("rst_csn", 32'(MEM_CSN), 32'd1);
        check("rst_wen", 32'(MEM_WEN), 32'd1);
        check("rst_be", 32'(MEM_BE), 32'd0);
        check("rst_addr", 32'(MEM_ADDR), 32'd0);
        check("rst_di", MEM_DI, 32'd0);
        RSTn = 1'b1;
        @(negedge CLK);

        do_req("lw_4",   1'b0, 3'b010, 32'h4, '0, 32'h44332211, 1'b0, 2, 1, mk(1'b1, 12'd1, 4'b1111, '0), na);
        do_req("lb_7",   1'b0, 3'b000, 32'h7, '0, 32'h00000044, 1'b0, 2, 1, mk(1'b1, 12'd1, 4'b1000, '0), na);
        do_req("lb_b",   1'b0, 3'b000, 32'hB, '0, 32'hFFFFFF88, 1'b0, 2, 1, mk(1'b1, 12'd2, 4'b1000, '0), na);
        do_req("lhu_a",  1'b0, 3'b101, 32'hA, '0, 32'h00008877, 1'b0, 2, 1, mk(1'b1, 12'd2, 4'b1100, '0), na);
        do_req("lh_a",   1'b0, 3'b001, 32'hA, '0, 32'hFFFF8877, 1'b0, 2, 1, mk(1'b1, 12'd2, 4'b1100, '0), na);
        do_req("lh_6",   1'b0, 3'b001, 32'h6, '0, 32'h00004433, 1'b0, 2, 1, mk(1'b1, 12'd1, 4'b1100, '0), na);
        do_req("lw_oor", 1'b0, 3'b010, 32'h4000, '0, 32'h0, 1'b1, 1, 0, na, na);
        do_req("ld_f3_3", 1'b0, 3'b011, 32'h4, '0, 32'h0, 1'b1, 1, 0, na, na);
        do_req("st_f3_3", 1'b1, 3'b011, 32'h4, 32'h1, 32'h0, 1'b1, 1, 0, na, na);
`ifdef MISALIGN_SPLIT_EN
        do_req("lw_6",    1'b0, 3'b010, 32'h6, '0, 32'h66554433, 1'b0, 3, 2,
               mk(1'b1, 12'd1, 4'b1100, '0), mk(1'b1, 12'd2, 4'b0011, '0));
        do_req("lw_wrap", 1'b0, 3'b010, 32'h3FFE, '0, 32'h5678CAFE, 1'b0, 3, 2,
               mk(1'b1, 12'hFFF, 4'b1100, '0), mk(1'b1, 12'd0, 4'b0011, '0));
        do_req("lh_7",    1'b0, 3'b001, 32'h7, '0, 32'h00005544, 1'b0, 3, 2,
               mk(1'b1, 12'd1, 4'b1000, '0), mk(1'b1, 12'd2, 4'b0001, '0));
`else
        do_req("lw_6_err", 1'b0, 3'b010, 32'h6, '0, 32'h0, 1'b1, 1, 0, na, na);
        do_req("lh_7_err", 1'b0, 3'b001, 32'h7, '0, 32'h0, 1'b1, 1, 0, na, na);
`endif
        do_req("sb_5",    1'b1, 3'b000, 32'h5, 32'h000000EE, 32'h0, 1'b0, 1, 1,
               mk(1'b0, 12'd1, 4'b0010, 32'h0000EE00), na);
        do_req("lw_4_sb", 1'b0, 3'b010, 32'h4, '0, 32'h4433EE11, 1'b0, 2, 1, mk(1'b1, 12'd1, 4'b1111, '0), na);
`ifdef MISALIGN_SPLIT_EN
        do_req("sw_7",    1'b1, 3'b010, 32'h7, 32'hDDCCBBAA, 32'h0, 1'b0, 2, 2,
               mk(1'b0, 12'd1, 4'b1000, 32'hAA000000), mk(1'b0, 12'd2, 4'b0111, 32'h00DDCCBB));
        do_req("lw_4_sw", 1'b0, 3'b010, 32'h4, '0, 32'hAA33EE11, 1'b0, 2, 1, mk(1'b1, 12'd1, 4'b1111, '0), na);
        do_req("lw_8_sw", 1'b0, 3'b010, 32'h8, '0, 32'h88DDCCBB, 1'b0, 2, 1, mk(1'b1, 12'd2, 4'b1111, '0), na);
        last_w1 = 32'hAA33EE11;
        REQ_ADDR = 32'h6;
`else
        last_w1 = 32'h4433EE11;
        REQ_ADDR = 32'h4;
`endif

        // Reset lands on the edge ending the second access (split) or the read-wait cycle.
        REQ_VALID  = 1'b1;
        REQ_WE     = 1'b0;
        REQ_FUNCT3 = 3'b010;
        @(posedge CLK);
        #1 REQ_VALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RSTn = 1'b0;
        @(negedge CLK);
        check("mid_rst_csn", 32'(MEM_CSN), 32'd1);
        check("mid_rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        RSTn = 1'b1;
        @(negedge CLK);
        check("post_rst_ready", 32'(REQ_READY), 32'd1);
        check("post_rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        do_req("lw_4_post", 1'b0, 3'b010, 32'h4, '0, last_w1, 1'b0, 2, 1, mk(1'b1, 12'd1, 4'b1111, '0), na);

        @(negedge CLK);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench time limit reached");
    end

endmodule
